// File: rtl/counter_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl_if
//
// Purpose:
//   Read interface between the sweep controller and the per-FIFO push-counter
//   bank. The controller presents an index with a request. The bank answers
//   with a count qualified by valid.
//
// Parameters:
//   IDX_W   width of the bank index bus
//   DATA_W  width of one count word
//
// Signals:
//   cnt_req    controller -> bank   read request
//   cnt_idx    controller -> bank   counter index being read
//   cnt_data   bank -> controller   returned count
//   cnt_valid  bank -> controller   qualifier for cnt_data
//
// Modports:
//   master  the sweep controller
//   slave   the counter bank
// ---------------------------------------------------------------------------
interface counter_sweep_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 6
);
    logic              cnt_req;
    logic [IDX_W-1:0]  cnt_idx;
    logic [DATA_W-1:0] cnt_data;
    logic              cnt_valid;

    modport master (
        output cnt_req,
        output cnt_idx,
        input  cnt_data,
        input  cnt_valid
    );

    modport slave (
        input  cnt_req,
        input  cnt_idx,
        output cnt_data,
        output cnt_valid
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Purpose:
//   This block sits in front of the push-counter bank. A start command begins
//   a sweep over the counters selected by sweep_mask, one index at a time. For
//   each selected index, the block raises a request, waits for valid, and
//   stores the returned count in a snapshot register. At the end of the sweep
//   it pulses done. The rest of the design then sees a consistent set of
//   counts and never has to drive the bank directly.
//
// Parameters:
//   NUM_CH   number of counters in the bank
//   DATA_W   width of one count word
//   IDX_W    width of the bank index bus (2**IDX_W > NUM_CH)
//   TIMEOUT  maximum cycles to wait for valid on one index.
//            Used only when the timeout feature is enabled.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   reset_L     asynchronous active-low reset
//   start       sweep request, sampled only while idle
//   sweep_mask  channel select, latched when start is accepted
//   bank        counter bank read interface (master side)
//   snap        snapshot registers; channel i at [i*DATA_W +: DATA_W]
//   busy        high whenever a sweep is in progress
//   done        one-cycle pulse when a sweep completes
//   err         per-channel timeout flags
//
// Optional feature:
//   SWEEP_TIMEOUT_EN. When defined, a wait counter limits each request to
//   TIMEOUT cycles. A request that times out stores all ones and sets the
//   err bit for that channel. When not defined, a request waits indefinitely
//   and err is tied to zero.
// ---------------------------------------------------------------------------
module counter_sweep_ctrl #(
    parameter int NUM_CH  = 5,
    parameter int DATA_W  = 6,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        sweep_mask,
    counter_sweep_ctrl_if.master     bank,
    output logic [NUM_CH*DATA_W-1:0] snap,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH-1:0]        err
);

    // ptr has to reach NUM_CH, which marks the end of the sweep
    localparam int PTR_W = $clog2(NUM_CH + 1);

    if (((2 ** IDX_W) <= NUM_CH) || (TIMEOUT < 1)) begin : g_param_check
        $error("counter_sweep_ctrl: IDX_W too small for NUM_CH or TIMEOUT < 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state, state_nx;
    logic [PTR_W-1:0]          ptr, ptr_nx;
    logic [NUM_CH-1:0]         mask, mask_nx;
    logic [NUM_CH-1:0]         mask_shift;
    logic [NUM_CH*DATA_W-1:0]  snap_nx;
    logic                      req_nx;
    logic [IDX_W-1:0]          idx_nx;
    logic                      busy_nx;
    logic                      done_nx;
    logic                      capture;
    logic [DATA_W-1:0]         capture_data;

`ifdef SWEEP_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0]         wait_cnt, wait_nx;
    logic [NUM_CH-1:0]         err_q, err_nx;
    logic                      capture_err;

    assign err = err_q;
`else
    assign err = '0;
`endif

    // Next-state and next-output logic. Every register has its next value
    // computed here, so all outputs come straight from flops. A capture (a
    // valid response or, when enabled, a timeout) is handled in one shared
    // place below the case statement.
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        mask_nx      = mask;
        snap_nx      = snap;
        req_nx       = bank.cnt_req;
        idx_nx       = bank.cnt_idx;
        capture      = 1'b0;
        capture_data = bank.cnt_data;
        mask_shift   = mask >> ptr;
`ifdef SWEEP_TIMEOUT_EN
        wait_nx      = wait_cnt;
        err_nx       = err_q;
        capture_err  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    mask_nx  = sweep_mask;
                    ptr_nx   = '0;
                    state_nx = CHECK;
`ifdef SWEEP_TIMEOUT_EN
                    err_nx   = '0;
`endif
                end
            end

            CHECK: begin
                if (ptr == PTR_W'(NUM_CH)) begin
                    state_nx = DONE;
                end else if (mask_shift[0]) begin
                    req_nx   = 1'b1;
                    idx_nx   = IDX_W'(ptr);
                    state_nx = REQ;
`ifdef SWEEP_TIMEOUT_EN
                    wait_nx  = '0;
`endif
                end else begin
                    ptr_nx = ptr + PTR_W'(1);
                end
            end

            REQ: begin
                // If valid and the timeout land on the same cycle, valid wins.
                if (bank.cnt_valid) begin
                    capture = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    capture      = 1'b1;
                    capture_data = '1;
                    capture_err  = 1'b1;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
`endif
                end

                if (capture) begin
                    req_nx   = 1'b0;
                    ptr_nx   = ptr + PTR_W'(1);
                    state_nx = CHECK;
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // Only the channel that ptr points at is written. All other channels
        // keep their snapshot from earlier sweeps.
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture && (ptr == PTR_W'(i))) begin
                snap_nx[i*DATA_W +: DATA_W] = capture_data;
`ifdef SWEEP_TIMEOUT_EN
                err_nx[i] = capture_err;
`endif
            end
        end

        // done is raised on the edge that leaves DONE, so it rises on the
        // same edge that busy falls.
        busy_nx = (state_nx != IDLE);
        done_nx = (state == DONE);
    end

    // State and output registers. Reset clears everything at once, even in
    // the middle of a sweep.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            ptr          <= '0;
            mask         <= '0;
            snap         <= '0;
            bank.cnt_req <= 1'b0;
            bank.cnt_idx <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            mask         <= mask_nx;
            snap         <= snap_nx;
            bank.cnt_req <= req_nx;
            bank.cnt_idx <= idx_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    // Wait counter and timeout flags. These exist only when the feature is
    // enabled.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wait_cnt <= '0;
            err_q    <= '0;
        end else begin
            wait_cnt <= wait_nx;
            err_q    <= err_nx;
        end
    end
`endif

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that sits in front of the per-FIFO push-counter bank.
- On a start command it walks the selected counter indices, drives the bank's req/idx read interface one index at a time and waits for valid on each.
- Captures each returned count into a snapshot register, then pulses done.
- Gives the rest of the design a consistent view of all counts without hand-driving idx/req.

Parameters:
NUM_CH, 5, number of counters in the bank (indices 0..NUM_CH-1)
DATA_W, 6, width of one count word returned by the bank
IDX_W, 3, width of the bank index bus; must satisfy 2**IDX_W > NUM_CH
TIMEOUT, 8, max cycles to wait for valid per index (used only with the optional feature)

Ports:
clk  input  1  single clock; all state updates on posedge
reset_L  input  1  asynchronous, active-low reset
start  input  1  request a sweep; sampled only in IDLE
sweep_mask  input  NUM_CH  bit i=1 selects counter i; latched on accepted start
cnt_req  output  1  read request to counter bank
cnt_idx  output  IDX_W  index presented to counter bank
cnt_data  input  DATA_W  count returned by bank
cnt_valid  input  1  bank qualifier for cnt_data
snap  output  NUM_CH*DATA_W  snapshot registers; channel i at bits [i*DATA_W +: DATA_W]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of sweep
err  output  NUM_CH  per-channel timeout flags (constant 0 without the optional feature)

Behaviour:
- Reset (reset_L=0, takes effect immediately, mid-sweep included):
  - state=IDLE; cnt_req=0, cnt_idx=0, snap=0, busy=0, done=0, err=0; latched mask=0, ptr=0.
- All outputs are registered.
- FSM states: IDLE, CHECK, REQ, DONE.
- IDLE:
  - start=1 -> latch sweep_mask, ptr<=0, err<=0, go CHECK.
  - start=0 -> stay IDLE.
- CHECK, evaluated one index per cycle:
  - ptr==NUM_CH -> go DONE.
  - mask[ptr]=1 -> cnt_req<=1, cnt_idx<=ptr, go REQ.
  - mask[ptr]=0 -> ptr<=ptr+1, stay CHECK.
- REQ:
  - cnt_req and cnt_idx are held stable.
  - cnt_valid=1 -> snap[ptr]<=cnt_data, cnt_req<=0, ptr<=ptr+1, go CHECK.
  - cnt_req is therefore low for at least one cycle between consecutive indices.
  - cnt_valid=0 -> stay REQ.
- DONE: done=1 for exactly one cycle, go IDLE; busy drops on the same edge.
- Sweep length: 1 + NUM_CH (CHECK cycles) + sum over selected channels of (cycles in REQ) + 1 (DONE).
- Channels not selected keep their previous snap value.
- cnt_valid outside REQ is ignored.
- start while busy is ignored, not queued.
- sweep_mask changes during a sweep have no effect.
- sweep_mask=0: start -> NUM_CH+1 CHECK cycles -> done pulse; cnt_req never asserts.
- Minimum bank latency supported: valid in the first cycle cnt_req is visible (zero-wait).

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ and increments each cycle in REQ.
  - If it reaches TIMEOUT with no cnt_valid: snap[ptr]<=all ones, err[ptr]<=1, cnt_req<=0, ptr++, go CHECK.
  - cnt_valid in the same cycle as the timeout wins (normal capture, no err).
- Undefined: REQ waits indefinitely; err is tied to 0; no wait counter is synthesized.

Test Plan:
- Reset mid-REQ (cnt_req=1, idx=2) -> cnt_req, busy, snap, done all 0 immediately, before the next clk edge.
- mask=5'b11111, bank returns valid 1 cycle after req with data 3,5,7,1,0 -> snap={0,1,7,5,3} (ch4..ch0), one done pulse, cnt_idx sequence 0,1,2,3,4 with req low between each.
- mask=5'b00101, zero-wait bank, data 9 on idx0 and 12 on idx2 -> only idx 0 and 2 requested; snap ch0=9, ch2=12; others unchanged; done 9 cycles after start accepted.
- mask=0 -> done exactly NUM_CH+2 cycles after start, cnt_req never high; second start during busy -> no extra sweep.
- SWEEP_TIMEOUT_EN, TIMEOUT=8, bank silent on idx1, mask=5'b00011 -> idx1 held 8 cycles, snap ch1=6'h3F, err=5'b00010, sweep completes with done.
- Without SWEEP_TIMEOUT_EN, valid delayed 20 cycles on idx0 -> req held 20 cycles, capture correct, err=0.
